// File: rtl/arm_pipe_hazard_unit.sv
// Hazard and forwarding controller for a 5-stage ARM pipeline (F, D, E, M, W).
// Adds a multi-cycle data-memory wait FSM and a saturating stall-cycle counter.
module arm_pipe_hazard_unit #(
  parameter int unsigned NREG     = 16,
  parameter int unsigned PC_REG   = NREG - 1,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned RA_W    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  RA1D,
  input  logic [RA_W-1:0]  RA2D,
  input  logic [RA_W-1:0]  RA1E,
  input  logic [RA_W-1:0]  RA2E,
  input  logic [RA_W-1:0]  WA3E,
  input  logic [RA_W-1:0]  WA3M,
  input  logic [RA_W-1:0]  WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemBusy,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [RA_W-1:0]  PcIdx    = RA_W'(PC_REG);
  localparam bit               WaitEn   = (LOAD_LAT > 1);
  // Counter preload is only meaningful when the wait FSM is enabled.
  localparam logic [3:0]       CntLoad  = WaitEn ? 4'(LOAD_LAT - 2) : 4'd0;
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

  typedef enum logic [0:0] {StIdle, StWait} wait_state_e;

  wait_state_e      state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic mem_stall;
  logic ldr_stall;
  logic pc_wr_pend;

  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] ra,
    input logic            wr_m,
    input logic [RA_W-1:0] wa_m,
    input logic            wr_w,
    input logic [RA_W-1:0] wa_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != PcIdx) begin
      if (wr_m && (wa_m == ra)) begin
        sel = 2'b10;
      end else if (wr_w && (wa_w == ra)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  // Wait FSM: a load stays in M for LOAD_LAT cycles, LOAD_LAT-1 of them stalled.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    if (WaitEn) begin
      case (state_q)
        StIdle: begin
          if (MemtoRegM) begin
            mem_stall = 1'b1;
            state_d   = StWait;
            cnt_d     = CntLoad;
          end
        end
        StWait: begin
          if (cnt_q != 4'd0) begin
            mem_stall = 1'b1;
            cnt_d     = cnt_q - 4'd1;
          end else begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    ldr_stall  = MemtoRegE && RegWriteE && (WA3E != PcIdx) &&
                 ((WA3E == RA1D) || (WA3E == RA2D));
    pc_wr_pend = PCSrcD || PCSrcE || PCSrcM;
  end

  // All controls are forced quiet while reset is asserted.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    MemBusy   = 1'b0;
    if (reset) begin
      ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
      ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
      MemBusy   = mem_stall;
      if (mem_stall) begin
        // Freeze F..M and bubble W; load-use and branch flushes wait for release.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = ldr_stall || pc_wr_pend;
        StallD = ldr_stall;
        FlushD = pc_wr_pend || PCSrcW || BranchTakenE;
        FlushE = ldr_stall || BranchTakenE;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (StallF && (stall_count_q != CntMax)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_arm_pipe_hazard_unit.sv
// Directed bench for arm_pipe_hazard_unit: three instances (LOAD_LAT 1, 4, 3) share stimulus.
module tb_arm_pipe_hazard_unit;

  logic       clk;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;

  logic [1:0]  a_fa, a_fb, b_fa, b_fb, c_fa, c_fb;
  logic        a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fw, a_mb;
  logic        b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fw, b_mb;
  logic        c_sf, c_sd, c_se, c_sm, c_fd, c_fe, c_fw, c_mb;
  logic [3:0]  a_cnt;
  logic [15:0] b_cnt, c_cnt;
  logic [7:0]  a_ctl, b_ctl, c_ctl;

  int total = 0;
  int bad   = 0;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemBusy}
  assign a_ctl = {a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fw, a_mb};
  assign b_ctl = {b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fw, b_mb};
  assign c_ctl = {c_sf, c_sd, c_se, c_sm, c_fd, c_fe, c_fw, c_mb};

  arm_pipe_hazard_unit #(.LOAD_LAT(1), .CNT_W(4)) u_a (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .PCSrcD(PCSrcD),
    .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .ForwardAE(a_fa), .ForwardBE(a_fb), .StallF(a_sf), .StallD(a_sd), .StallE(a_se),
    .StallM(a_sm), .FlushD(a_fd), .FlushE(a_fe), .FlushW(a_fw), .MemBusy(a_mb),
    .StallCount(a_cnt)
  );

  arm_pipe_hazard_unit #(.LOAD_LAT(4), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .PCSrcD(PCSrcD),
    .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .ForwardAE(b_fa), .ForwardBE(b_fb), .StallF(b_sf), .StallD(b_sd), .StallE(b_se),
    .StallM(b_sm), .FlushD(b_fd), .FlushE(b_fe), .FlushW(b_fw), .MemBusy(b_mb),
    .StallCount(b_cnt)
  );

  arm_pipe_hazard_unit #(.LOAD_LAT(3), .CNT_W(16)) u_c (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .PCSrcD(PCSrcD),
    .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .ForwardAE(c_fa), .ForwardBE(c_fb), .StallF(c_sf), .StallD(c_sd), .StallE(c_se),
    .StallM(c_sm), .FlushD(c_fd), .FlushE(c_fe), .FlushW(c_fw), .MemBusy(c_mb),
    .StallCount(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
    WA3E = '0; WA3M = '0; WA3W = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0;
    PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
    BranchTakenE = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [5:0] pat;
    reset = 1'b0;
    clear_inputs();

    // Everything quiet while reset is held, even with hazards present.
    #2;
    MemtoRegM = 1'b1; PCSrcD = 1'b1; BranchTakenE = 1'b1;
    RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3;
    #1;
    chk("rst_a_ctl", a_ctl, 8'h00);
    chk("rst_b_ctl", b_ctl, 8'h00);
    chk("rst_a_fwd", a_fa, 2'b00);
    chk("rst_b_cnt", b_cnt, 16'd0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;

    // Forwarding priority and PC exclusion.
    RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3;
    RegWriteW = 1'b1; WA3W = 4'd3; RA2E = 4'd7;
    #1;
    chk("fwdA_m", a_fa, 2'b10);
    chk("fwdB_none", a_fb, 2'b00);
    RegWriteM = 1'b0;
    #1;
    chk("fwdA_w", a_fa, 2'b01);
    RA2E = 4'd3;
    #1;
    chk("fwdB_w", a_fb, 2'b01);
    RA1E = 4'd15;
    #1;
    chk("fwdA_pc", a_fa, 2'b00);
    RegWriteM = 1'b1; WA3M = 4'd15; WA3W = 4'd15; RA2E = 4'd15;
    #1;
    chk("fwdB_pc", a_fb, 2'b00);
    WA3W = 4'd3; RA2E = 4'd3;
    #1;
    chk("fwdB_w_m_miss", a_fb, 2'b01);
    clear_inputs();

    // Load-use stall and flush combinations.
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
    #1;
    chk("ldr_stall", a_ctl, 8'b1100_0100);
    RA2D = 4'd6;
    #1;
    chk("ldr_none", a_ctl, 8'h00);
    WA3E = 4'd15; RA1D = 4'd15;
    #1;
    chk("ldr_pc", a_ctl, 8'h00);
    WA3E = 4'd5; RA1D = 4'd5; BranchTakenE = 1'b1;
    #1;
    chk("ldr_branch", a_ctl, 8'b1100_1100);
    clear_inputs();
    PCSrcW = 1'b1;
    #1;
    chk("pcsrc_w", a_ctl, 8'b0000_1000);
    PCSrcW = 1'b0; PCSrcE = 1'b1;
    #1;
    chk("pcsrc_e", a_ctl, 8'b1000_1000);
    clear_inputs();

    // LOAD_LAT=4: three stalled cycles then a release cycle.
    do_reset();
    @(posedge clk); #1;
    MemtoRegM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("lat4_cyc%0d", i), b_ctl, (i < 3) ? 8'b1111_0011 : 8'h00);
      @(posedge clk); #1;
    end
    MemtoRegM = 1'b0;
    #1;
    chk("lat4_idle", b_ctl, 8'h00);
    chk("lat4_cnt", b_cnt, 16'd3);
    chk("lat1_cnt", a_cnt, 4'd0);

    // LOAD_LAT=3: back-to-back loads, two windows split by a release cycle.
    do_reset();
    @(posedge clk); #1;
    MemtoRegM = 1'b1;
    pat = 6'b011011;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("lat3_cyc%0d", i), c_ctl, pat[i] ? 8'b1111_0011 : 8'h00);
      @(posedge clk); #1;
    end
    MemtoRegM = 1'b0;
    #1;
    chk("lat3_idle", c_ctl, 8'h00);
    chk("lat3_cnt", c_cnt, 16'd4);

    // Branch during WAIT is deferred to the release cycle; then reset mid-WAIT.
    do_reset();
    @(posedge clk); #1;
    MemtoRegM = 1'b1; BranchTakenE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("br_wait_cyc%0d", i), b_ctl, (i < 3) ? 8'b1111_0011 : 8'b0000_1100);
      @(posedge clk); #1;
    end
    BranchTakenE = 1'b0;
    @(posedge clk); #1;
    #1;
    chk("wait_before_rst", b_ctl, 8'b1111_0011);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_wait_ctl", b_ctl, 8'h00);
    chk("rst_mid_wait_cnt", b_cnt, 16'd0);
    MemtoRegM = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", b_ctl, 8'h00);
    chk("post_rst_cnt", b_cnt, 16'd0);

    // CNT_W=4 saturation under a long PC-write stall.
    do_reset();
    @(posedge clk); #1;
    PCSrcD = 1'b1;
    #1;
    chk("pcsrc_d_ctl", a_ctl, 8'b1000_1000);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 14) chk("sat_cnt14", a_cnt, 4'd14);
      if (k == 20) chk("sat_cnt20", a_cnt, 4'd15);
    end
    PCSrcD = 1'b0;
    @(posedge clk); #1;
    chk("sat_hold", a_cnt, 4'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
